// File: rtl/ins_encoder.sv
// ins_encoder: builds MIPS32 instruction words from internal instruction codes
// and queues them in a small FIFO for the instruction-injection path.
module ins_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_inscode,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_sa,
  input  logic [15:0]      in_imm,
  input  logic [25:0]      in_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ins,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_FW = PTR_W + 1;

  logic [31:0]       encIns;
  logic              encValid;
  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_FW-1:0] fifoCount;
  logic              accept;
  logic              push;
  logic              pop;
  logic              errPulse;
  logic [CNT_W-1:0]  encCnt;
  logic [CNT_W-1:0]  errCnt;

  assign in_ready  = (fifoCount < CNT_FW'(DEPTH));
  assign out_valid = (fifoCount != '0);
  assign out_ins   = out_valid ? mem[rdPtr] : '0;
  assign out_err   = errPulse;
  assign enc_cnt   = encCnt;
  assign err_cnt   = errCnt;

  assign accept = in_valid & in_ready;
  assign push   = accept & encValid & ~flush;
  assign pop    = out_valid & out_ready & ~flush;

  // Map instruction code and operand fields to the encoded word; unused fields zero.
  always_comb begin
    encIns   = '0;
    encValid = 1'b1;
    case (in_inscode)
      // R-type ALU: rs, rt, rd
      6'd1:  encIns = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
      6'd3:  encIns = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};
      6'd5:  encIns = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
      6'd6:  encIns = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};
      6'd7:  encIns = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
      6'd9:  encIns = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2B};
      6'd15: encIns = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
      6'd18: encIns = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h27};
      6'd19: encIns = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
      6'd21: encIns = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h26};
      // multiply/divide: rs, rt only
      6'd11: encIns = {6'h00, in_rs, in_rt, 5'd0, 5'd0, 6'h1A};
      6'd12: encIns = {6'h00, in_rs, in_rt, 5'd0, 5'd0, 6'h1B};
      6'd13: encIns = {6'h00, in_rs, in_rt, 5'd0, 5'd0, 6'h18};
      6'd14: encIns = {6'h00, in_rs, in_rt, 5'd0, 5'd0, 6'h19};
      // immediate shifts
      6'd23: encIns = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h00};
      6'd25: encIns = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h03};
      6'd27: encIns = {6'h00, 5'd0, in_rt, in_rd, in_sa, 6'h02};
      // variable shifts
      6'd24: encIns = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h04};
      6'd26: encIns = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h07};
      6'd28: encIns = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h06};
      // register jumps, hi/lo moves, traps
      6'd39: encIns = {6'h00, in_rs, 5'd0, 5'd0, 5'd0, 6'h08};
      6'd40: encIns = {6'h00, in_rs, 5'd0, in_rd, 5'd0, 6'h09};
      6'd41: encIns = {6'h00, 5'd0, 5'd0, in_rd, 5'd0, 6'h10};
      6'd42: encIns = {6'h00, 5'd0, 5'd0, in_rd, 5'd0, 6'h12};
      6'd43: encIns = {6'h00, in_rs, 5'd0, 5'd0, 5'd0, 6'h11};
      6'd44: encIns = {6'h00, in_rs, 5'd0, 5'd0, 5'd0, 6'h13};
      6'd45: encIns = {6'h00, 20'd0, 6'h0D};
      6'd46: encIns = {6'h00, 20'd0, 6'h0C};
      // I-type
      6'd2:  encIns = {6'h08, in_rs, in_rt, in_imm};
      6'd4:  encIns = {6'h09, in_rs, in_rt, in_imm};
      6'd8:  encIns = {6'h0A, in_rs, in_rt, in_imm};
      6'd10: encIns = {6'h0B, in_rs, in_rt, in_imm};
      6'd16: encIns = {6'h0C, in_rs, in_rt, in_imm};
      6'd20: encIns = {6'h0D, in_rs, in_rt, in_imm};
      6'd22: encIns = {6'h0E, in_rs, in_rt, in_imm};
      6'd17: encIns = {6'h0F, 5'd0, in_rt, in_imm};
      6'd29: encIns = {6'h04, in_rs, in_rt, in_imm};
      6'd30: encIns = {6'h05, in_rs, in_rt, in_imm};
      6'd32: encIns = {6'h07, in_rs, 5'd0, in_imm};
      6'd33: encIns = {6'h06, in_rs, 5'd0, in_imm};
      // loads/stores
      6'd47: encIns = {6'h20, in_rs, in_rt, in_imm};
      6'd48: encIns = {6'h24, in_rs, in_rt, in_imm};
      6'd49: encIns = {6'h21, in_rs, in_rt, in_imm};
      6'd50: encIns = {6'h25, in_rs, in_rt, in_imm};
      6'd51: encIns = {6'h23, in_rs, in_rt, in_imm};
      6'd52: encIns = {6'h28, in_rs, in_rt, in_imm};
      6'd53: encIns = {6'h29, in_rs, in_rt, in_imm};
      6'd54: encIns = {6'h2B, in_rs, in_rt, in_imm};
      // REGIMM branches: condition selected by the rt field
      6'd31: encIns = {6'h01, in_rs, 5'h01, in_imm};
      6'd34: encIns = {6'h01, in_rs, 5'h00, in_imm};
      6'd35: encIns = {6'h01, in_rs, 5'h10, in_imm};
      6'd36: encIns = {6'h01, in_rs, 5'h11, in_imm};
      // J-type
      6'd37: encIns = {6'h02, in_target};
      6'd38: encIns = {6'h03, in_target};
      // COP0
      6'd55: encIns = 32'h4200_0018;
      6'd56: encIns = {6'h10, 5'h00, in_rt, in_rd, 11'd0};
      6'd57: encIns = {6'h10, 5'h04, in_rt, in_rd, 11'd0};
      default: encValid = 1'b0;
    endcase
  end

  // FIFO storage; contents need no reset since out_ins is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= encIns;
  end

  // FIFO pointers and occupancy; flush overrides push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else if (flush) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      fifoCount <= fifoCount + 1'b1;
      else if (pop && !push) fifoCount <= fifoCount - 1'b1;
    end
  end

  // Status: error pulse and wrapping counters; encodes count even when flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errPulse <= 1'b0;
      encCnt   <= '0;
      errCnt   <= '0;
    end else begin
      errPulse <= accept & ~encValid;
      if (accept && encValid)  encCnt <= encCnt + 1'b1;
      if (accept && !encValid) errCnt <= errCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ins_encoder.sv
// tb_ins_encoder: directed vectors with hand-computed instruction words.
module tb_ins_encoder;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [5:0]  inInscode;
  logic [4:0]  inRs;
  logic [4:0]  inRt;
  logic [4:0]  inRd;
  logic [4:0]  inSa;
  logic [15:0] inImm;
  logic [25:0] inTarget;
  logic        outValid;
  logic        outReady;
  logic [31:0] outIns;
  logic        outErr;
  logic [15:0] encCnt;
  logic [15:0] errCnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  ins_encoder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inValid), .in_ready(inReady),
    .in_inscode(inInscode), .in_rs(inRs), .in_rt(inRt), .in_rd(inRd),
    .in_sa(inSa), .in_imm(inImm), .in_target(inTarget),
    .out_valid(outValid), .out_ready(outReady), .out_ins(outIns),
    .out_err(outErr), .enc_cnt(encCnt), .err_cnt(errCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input logic [5:0] code, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                        input logic [25:0] target);
    inInscode = code; inRs = rs; inRt = rt; inRd = rd;
    inSa = sa; inImm = imm; inTarget = target;
  endtask

  task automatic send(input logic [5:0] code, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                      input logic [25:0] target);
    setReq(code, rs, rt, rd, sa, imm, target);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    setReq(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    repeat (3) tick();
    checkVal("rst_out_valid", 32'(outValid), 32'd0);
    checkVal("rst_out_ins", outIns, 32'd0);
    checkVal("rst_out_err", 32'(outErr), 32'd0);
    checkVal("rst_enc_cnt", 32'(encCnt), 32'd0);
    checkVal("rst_err_cnt", 32'(errCnt), 32'd0);
    rst = 1'b0;
    tick();
    checkVal("rel_in_ready", 32'(inReady), 32'd1);

    // add
    outReady = 1'b1;
    send(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    checkVal("add_valid", 32'(outValid), 32'd1);
    checkVal("add_ins", outIns, 32'h0022_1820);
    checkVal("add_enc_cnt", 32'(encCnt), 32'd1);
    tick();
    checkVal("add_drained", 32'(outValid), 32'd0);

    // lui then sll, ordered
    outReady = 1'b0;
    send(6'd17, 5'd0, 5'd4, 5'd0, 5'd0, 16'h1234, 26'd0);
    checkVal("lui_ins", outIns, 32'h3C04_1234);
    send(6'd23, 5'd0, 5'd5, 5'd6, 5'd2, 16'd0, 26'd0);
    checkVal("lui_head_hold", outIns, 32'h3C04_1234);
    checkVal("full_in_ready", 32'(inReady), 32'd0);
    outReady = 1'b1;
    tick();
    checkVal("sll_ins", outIns, 32'h0005_3080);
    tick();
    checkVal("ord_empty", 32'(outValid), 32'd0);

    // invalid codes
    send(6'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0);
    checkVal("inv0_err", 32'(outErr), 32'd1);
    checkVal("inv0_valid", 32'(outValid), 32'd0);
    send(6'd63, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0);
    checkVal("inv63_err", 32'(outErr), 32'd1);
    tick();
    checkVal("err_pulse_end", 32'(outErr), 32'd0);
    checkVal("inv_err_cnt", 32'(errCnt), 32'd2);
    checkVal("inv_enc_cnt", 32'(encCnt), 32'd3);
    checkVal("inv_no_valid", 32'(outValid), 32'd0);

    // backpressure, fill, drain with simultaneous push/pop
    outReady = 1'b0;
    send(6'd3, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0);
    checkVal("bp_ready1", 32'(inReady), 32'd1);
    send(6'd5, 5'd2, 5'd3, 5'd4, 5'd0, 16'd0, 26'd0);
    checkVal("bp_ready2", 32'(inReady), 32'd0);
    setReq(6'd6, 5'd5, 5'd6, 5'd7, 5'd0, 16'd0, 26'd0);
    inValid = 1'b1;
    tick();
    checkVal("bp_full_ready", 32'(inReady), 32'd0);
    checkVal("bp_head_stable", outIns, 32'h0021_0821);
    checkVal("bp_enc_cnt", 32'(encCnt), 32'd5);
    outReady = 1'b1;
    tick();
    checkVal("drain_b", outIns, 32'h0043_2022);
    checkVal("drain_ready", 32'(inReady), 32'd1);
    tick();
    inValid = 1'b0;
    checkVal("pushpop_c", outIns, 32'h00A6_3823);
    checkVal("pushpop_valid", 32'(outValid), 32'd1);
    checkVal("pushpop_enc_cnt", 32'(encCnt), 32'd6);
    tick();
    checkVal("drain_empty", 32'(outValid), 32'd0);

    // streaming mixed formats
    send(6'd55, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    checkVal("eret", outIns, 32'h4200_0018);
    send(6'd56, 5'd0, 5'd8, 5'd12, 5'd0, 16'd0, 26'd0);
    checkVal("mfc0", outIns, 32'h4008_6000);
    send(6'd31, 5'd9, 5'd0, 5'd0, 5'd0, 16'hFFFF, 26'd0);
    checkVal("bgez", outIns, 32'h0521_FFFF);
    send(6'd38, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h010_0000);
    checkVal("jal", outIns, 32'h0C10_0000);
    send(6'd39, 5'd31, 5'd7, 5'd7, 5'd3, 16'd0, 26'd0);
    checkVal("jr", outIns, 32'h03E0_0008);
    send(6'd51, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0010, 26'd0);
    checkVal("lw", outIns, 32'h8FA8_0010);
    tick();
    checkVal("stream_empty", 32'(outValid), 32'd0);
    checkVal("stream_enc_cnt", 32'(encCnt), 32'd12);

    // flush discards a same-cycle push but counts it
    outReady = 1'b0;
    send(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    flush = 1'b1;
    send(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    flush = 1'b0;
    checkVal("flush_valid", 32'(outValid), 32'd0);
    checkVal("flush_ready", 32'(inReady), 32'd1);
    checkVal("flush_enc_cnt", 32'(encCnt), 32'd14);

    // asynchronous reset mid-drain
    send(6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
    send(6'd3, 5'd1, 5'd1, 5'd1, 5'd0, 16'd0, 26'd0);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    checkVal("mid_valid", 32'(outValid), 32'd1);
    checkVal("mid_ins", outIns, 32'h0021_0821);
    #2 rst = 1'b1;
    #1;
    checkVal("arst_valid", 32'(outValid), 32'd0);
    checkVal("arst_ins", outIns, 32'd0);
    checkVal("arst_enc_cnt", 32'(encCnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkVal("arst_in_ready", 32'(inReady), 32'd1);
    checkVal("arst_empty", 32'(outValid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ins_encoder.md
Name: ins_encoder

Overview:
- Inverse of the instruction decoder: turns an internal instruction code (inscode 1..57) plus operand fields into a 32-bit MIPS32 instruction word.
- Used by the self-test/instruction-injection path to generate instruction streams for the CPU's instruction SRAM port.
- Valid/ready on input and output, with a small output FIFO and status counters.

Parameters:
DEPTH, 2, output FIFO entries (power of 2, ≥2)
CNT_W, 16, width of enc_cnt/err_cnt

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous clear of FIFO contents (counters kept)
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&in_ready
in_inscode  in  6  internal instruction code
in_rs/in_rt/in_rd/in_sa  in  5 each  register/shift fields
in_imm  in  16  immediate/offset
in_target  in  26  jump target
out_valid  out  1  out_ins valid
out_ready  in  1  consumer accepts
out_ins  out  32  encoded word (FIFO head)
out_err  out  1  one-cycle pulse: accepted request had invalid inscode
enc_cnt  out  CNT_W  words enqueued, wraps
err_cnt  out  CNT_W  invalid requests, wraps

Behaviour:
- Reset (async, rst=1):
  - FIFO empty, out_valid=0, out_ins=0, out_err=0, counters 0.
  - in_ready=1 on the first cycle after release.
- in_ready = (fifo_count < DEPTH), registered-state only; no combinational path from out_ready.
- Accept when in_valid&in_ready.
- Valid code: encode combinationally and push. out_valid rises on the next cycle if the FIFO was empty (latency 1). enc_cnt+1.
- Invalid code (0, unlisted, or >57): nothing pushed, out_err=1 next cycle, err_cnt+1.
- Pop when out_valid&out_ready.
  - Push and pop in the same cycle keep the count unchanged; this is legal at any count <DEPTH.
  - At full, no push occurs (in_ready=0).
- out_ins/out_valid stay stable while out_valid&!out_ready.
- flush=1:
  - Next cycle the FIFO is empty and out_valid=0.
  - A same-cycle accept is discarded, but still counted in enc_cnt.
  - flush has priority over push/pop.
- Pointers wrap mod DEPTH. Counters wrap 2^CNT_W-1 → 0.
- Unused fields are forced to 0.
- R-type {6'h00,rs,rt,rd,sa,funct}, inscode→funct:
  - 1→20, 3→21, 5→22, 6→23, 7→2A, 9→2B
  - 11→1A, 12→1B, 13→18, 14→19 (rd=0, sa=0)
  - 15→24, 18→27, 19→25, 21→26
  - 23→00, 25→03, 27→02 (rs=0, sa=in_sa)
  - 24→04, 26→07, 28→06
  - 39→08 (rt=rd=0), 40→09 (rt=0)
  - 41→10, 42→12 (rs=rt=0)
  - 43→11, 44→13 (rt=rd=0)
  - 45→0D, 46→0C (bits 25:6=0)
  - sa=0 for all non-shift codes.
- I-type {op,rs,rt,imm}, inscode→op:
  - 2→08, 4→09, 8→0A, 10→0B, 16→0C, 20→0D, 22→0E
  - 17→0F (rs=0)
  - 29→04, 30→05
  - 32→07, 33→06 (rt=0)
  - 47→20, 48→24, 49→21, 50→25, 51→23, 52→28, 53→29, 54→2B
- REGIMM op=01, rt field: 31→01, 34→00, 35→10, 36→11.
- J-type: 37→op 02, 38→op 03, {op,target}.
- COP0 op=10:
  - 55→42000018.
  - 56→{10,00000,rt,rd,11'b0}.
  - 57→{10,00100,rt,rd,11'b0}.
- Reset mid-stream: FIFO content lost, outputs return to reset values immediately (async).

Test Plan:
1. inscode=1, rs=1, rt=2, rd=3, out_ready=1 → next cycle out_valid=1, out_ins=00221820, enc_cnt=1.
2. inscode=17, rt=4, imm=1234; inscode=23, rt=5, rd=6, sa=2 → 3C041234, then 00053080, in order.
3. inscode=0, then 63 → no out_valid, out_err pulses twice, err_cnt=2, enc_cnt unchanged.
4. out_ready=0, push 3 valid words → in_ready=0 after 2 (DEPTH=2), head stable. Raise out_ready → drains in order, in_ready=1 again; simultaneous push/pop holds count.
5. Push 55, 56 (rt=8, rd=12), 31 (rs=9, imm=FFFF), 38 (target=0100000) → 42000018, 40086000, 0521FFFF, 0C100000.
6. Push 2 words, assert flush alongside a new push → out_valid=0 next cycle. Assert rst mid-drain → outputs 0 immediately, in_ready=1 after release.
